// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
// Writeback stage that owns the register file's single write port. Two result
// sources are merged: the in-order pipeline (always accepted, highest priority)
// and a long-latency unit (valid/ready) whose results are buffered in a small
// FIFO. A wait counter on the FIFO head raises o_stall_req so the pipeline
// leaves a bubble and buffered results always drain.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pipe_valid/rd/data    pipeline result (never back-pressured)
//   i_lu_valid/rd/data      long-latency result, handshake with o_lu_ready
//   o_lu_ready              FIFO has room (registered occupancy)
//   o_wr_en/reg/data        registered register-file write port
//   o_stall_req             registered request to hold pipe_valid low
//   o_fifo_count            current FIFO occupancy
module reg_writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_pipe_valid,
  input  logic [ADDR_WIDTH-1:0]         i_pipe_rd,
  input  logic [DATA_WIDTH-1:0]         i_pipe_data,
  input  logic                          i_lu_valid,
  output logic                          o_lu_ready,
  input  logic [ADDR_WIDTH-1:0]         i_lu_rd,
  input  logic [DATA_WIDTH-1:0]         i_lu_data,
  output logic                          o_wr_en,
  output logic [ADDR_WIDTH-1:0]         o_wr_reg,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic                          o_stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] r_fifo_rd;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] r_fifo_data;
  logic [PW-1:0]          r_wptr, r_rptr;
  logic [CW-1:0]          r_count;
  logic [WW-1:0]          r_wait;
  logic                   r_live;   // keeps lu_ready low until the first edge after reset
  logic                   r_stall;
  logic                   r_wr_en;
  logic [ADDR_WIDTH-1:0]  r_wr_reg;
  logic [DATA_WIDTH-1:0]  r_wr_data;

  logic w_pipe_win, w_pop, w_push, w_empty;

  assign w_empty    = (r_count == '0);
  assign o_lu_ready = r_live && (r_count < CW'(FIFO_DEPTH));
  // pipe_rd==0 is a dropped write and leaves the port free for the FIFO
  assign w_pipe_win = i_pipe_valid && (i_pipe_rd != '0);
  assign w_pop      = !w_pipe_win && !w_empty;
  // x0 results complete the handshake but are never stored
  assign w_push     = i_lu_valid && o_lu_ready && (i_lu_rd != '0);

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= i_lu_rd;
      r_fifo_data[r_wptr] <= i_lu_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_wait    <= '0;
      r_stall   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      r_live  <= 1'b1;
      // pointers wrap naturally since FIFO_DEPTH is a power of two
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      // head wait counter saturates at the limit
      if (w_pop || w_empty)
        r_wait <= '0;
      else if (r_wait != WW'(STARVE_LIMIT))
        r_wait <= r_wait + WW'(1);

      if (w_pop)
        r_stall <= 1'b0;
      else if (r_wait == WW'(STARVE_LIMIT))
        r_stall <= 1'b1;

      if (w_pipe_win) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= i_pipe_rd;
        r_wr_data <= i_pipe_data;
      end else if (w_pop) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= r_fifo_rd[r_rptr];
        r_wr_data <= r_fifo_data[r_rptr];
      end else begin
        r_wr_en   <= 1'b0;
      end
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_reg     = r_wr_reg;
  assign o_wr_data    = r_wr_data;
  assign o_stall_req  = r_stall;
  assign o_fifo_count = r_count;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 2, LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pv = 1'b0, lv = 1'b0;
  logic [AW-1:0] prd = '0, lrd = '0;
  logic [DW-1:0] pdata = '0, ldata = '0;
  logic          lu_ready, wr_en, stall_req;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0, errors = 0;

  reg_writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
                          .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pipe_valid(pv), .i_pipe_rd(prd), .i_pipe_data(pdata),
    .i_lu_valid(lv), .o_lu_ready(lu_ready), .i_lu_rd(lrd), .i_lu_data(ldata),
    .o_wr_en(wr_en), .o_wr_reg(wr_reg), .o_wr_data(wr_data),
    .o_stall_req(stall_req), .o_fifo_count(fifo_count));

  always #5 clk = ~clk;

  // Reference model: a queue of buffered results plus the observable outputs.
  logic [AW+DW-1:0] m_q[$];
  int               m_wait;
  bit               m_stall, m_live, m_wr_en;
  logic [AW-1:0]    m_wr_reg;
  logic [DW-1:0]    m_wr_data;

  task automatic model_reset();
    m_q.delete();
    m_wait = 0; m_stall = 0; m_live = 0;
    m_wr_en = 0; m_wr_reg = '0; m_wr_data = '0;
  endtask

  function automatic bit model_ready();
    return m_live && (m_q.size() < DEPTH);
  endfunction

  task automatic model_step();
    bit pipe_win, pop, push, was_busy;
    logic [AW+DW-1:0] head;
    pipe_win = pv && (prd != 0);
    was_busy = (m_q.size() > 0);
    pop  = !pipe_win && was_busy;
    push = lv && model_ready() && (lrd != 0);
    if (pipe_win) begin
      m_wr_en = 1; m_wr_reg = prd; m_wr_data = pdata;
    end else if (pop) begin
      head = m_q.pop_front();
      m_wr_en = 1; m_wr_reg = head[AW+DW-1:DW]; m_wr_data = head[DW-1:0];
    end else
      m_wr_en = 0;
    if (push) m_q.push_back({lrd, ldata});
    if (pop) begin
      m_wait = 0; m_stall = 0;
    end else if (was_busy) begin
      if (m_wait == LIMIT) m_stall = 1;
      if (m_wait < LIMIT) m_wait++;
    end else
      m_wait = 0;
    m_live = 1;
  endtask

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("wr_en", DW'(wr_en), DW'(m_wr_en));
    chk("wr_reg", DW'(wr_reg), DW'(m_wr_reg));
    chk("wr_data", wr_data, m_wr_data);
    chk("stall_req", DW'(stall_req), DW'(m_stall));
    chk("fifo_count", DW'(fifo_count), DW'(m_q.size()));
  endtask

  // One cycle: drive at the negedge, check lu_ready, step model, check after posedge.
  task automatic cycle(bit rst, bit p_v, logic [AW-1:0] p_rd, logic [DW-1:0] p_d,
                       bit l_v, logic [AW-1:0] l_rd, logic [DW-1:0] l_d);
    rst_n = rst; pv = p_v; prd = p_rd; pdata = p_d; lv = l_v; lrd = l_rd; ldata = l_d;
    if (!rst) model_reset();
    #1;
    chk("lu_ready", DW'(lu_ready), DW'(model_ready()));
    if (rst) model_step();
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // reset held with both sources active
    for (int i = 0; i < 3; i++) cycle(0, 1, 5'd9, 32'h1, 1, 5'd4, 32'h2);
    chk("rst_wr_en", DW'(wr_en), 0);
    chk("rst_lu_ready", DW'(lu_ready), 0);
    // first edge after release: lu_ready still low before it
    cycle(1, 0, 0, 0, 0, 0, 0);
    // pipe only
    cycle(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    chk("pipe_reg", DW'(wr_reg), 5);
    chk("pipe_data", wr_data, 32'hDEADBEEF);
    cycle(1, 1, 5'd0, 32'h1234, 0, 0, 0);
    chk("pipe_x0_drop", DW'(wr_en), 0);
    // priority and drain
    cycle(1, 1, 5'd3, 32'hA, 1, 5'd7, 32'h11);
    cycle(1, 1, 5'd3, 32'hB, 0, 0, 0);
    chk("prio_pipe", DW'(wr_reg), 3);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("drain_reg", DW'(wr_reg), 7);
    chk("drain_data", wr_data, 32'h11);
    // full: third push held off
    cycle(1, 1, 5'd8, 32'h80, 1, 5'd1, 32'h101);
    cycle(1, 1, 5'd8, 32'h81, 1, 5'd2, 32'h102);
    cycle(1, 1, 5'd8, 32'h82, 1, 5'd3, 32'h103);
    chk("full_count", DW'(fifo_count), 2);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, i < 2, 5'd3, 32'h103);
    // starvation
    cycle(1, 1, 5'd6, 32'h60, 1, 5'd12, 32'hC0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 5'd6, 32'h61 + i, 0, 0, 0);
    chk("starve_stall", DW'(stall_req), 1);
    cycle(1, 1, 5'd6, 32'h70, 0, 0, 0);
    chk("starve_hold", DW'(stall_req), 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("starve_pop_reg", DW'(wr_reg), 12);
    chk("starve_clear", DW'(stall_req), 0);
    // async reset with two buffered entries
    cycle(1, 1, 5'd2, 32'h20, 1, 5'd10, 32'hA0);
    cycle(1, 1, 5'd2, 32'h21, 1, 5'd11, 32'hB0);
    chk("pre_rst_count", DW'(fifo_count), 2);
    #2 rst_n = 0; #1;
    model_reset();
    chk("async_count", DW'(fifo_count), 0);
    chk("async_wr_en", DW'(wr_en), 0);
    @(negedge clk);
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("no_stale_write", DW'(wr_en), 0);
    end
    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 70,
            AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)), $urandom,
            $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)), $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
